// File: rtl/dm_multicycle_pkg.sv
// Shared constants and types for the multi-cycle data memory.
// Size encodings, FSM states and the captured-request payload.
package dm_multicycle_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BE_W   = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              ld_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

  // Size 2'b11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lo[0];
      default:   misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/dm_multicycle_lane_align.sv
// Byte-lane steering: store byte-enables / shifted write word, and load
// lane extraction with sign or zero extension.
module dm_lane_align
  import dm_multicycle_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ld_unsigned,
  input  logic [DATA_W-1:0] rword,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wword_c,
  output logic [DATA_W-1:0] ldata_c
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  // Store side: replicate the low bits so every enabled lane sees them.
  always_comb begin
    be_c    = 4'hF;
    wword_c = wdata;
    case (size)
      SIZE_BYTE: begin
        be_c    = 4'b0001 << addr_lo;
        wword_c = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'hF;
        wword_c = wdata;
      end
    endcase
  end

  // Load side.
  always_comb begin
    lbyte   = 8'(rword >> {addr_lo, 3'b000});
    lhalf   = 16'(rword >> {addr_lo[1], 4'b0000});
    ldata_c = rword;
    case (size)
      SIZE_BYTE: ldata_c = ld_unsigned ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
      SIZE_HALF: ldata_c = ld_unsigned ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
      default:   ldata_c = rword;
    endcase
  end

endmodule

// File: rtl/dm_multicycle.sv
// Multi-cycle byte-addressable data memory with programmable latency,
// req/busy/done handshake and address-exception reporting.
module dm_multicycle
  import dm_multicycle_pkg::*;
#(
  parameter int unsigned DEPTH     = 3072,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] ADDR_END = 33'(ADDR_BASE) + 33'(4 * DEPTH);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dm_req_t           cur_q;
  logic              accept_c, access_c;
  logic [ADDR_W-1:0] offset_c;
  logic [IDX_W-1:0]  idx_c;
  logic              in_range_c, exc_c;
  logic [DATA_W-1:0] rword_c, wword_c, ldata_c;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state logic: accept from IDLE or DONE, count down in BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    access_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (req) begin
          accept_c = 1'b1;
          cnt_d    = CNT_W'(LATENCY);
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          access_c = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_c) cur_q <= {we, size, ld_unsigned, addr, wdata};
    end
  end

  // Address decode and exception check on the captured request.
  always_comb begin
    offset_c   = cur_q.addr - ADDR_BASE;
    idx_c      = IDX_W'(offset_c >> 2);
    in_range_c = (cur_q.addr >= ADDR_BASE) && (33'(cur_q.addr) < ADDR_END);
    exc_c      = !in_range_c || misaligned(cur_q.size, cur_q.addr[1:0]);
    rword_c    = in_range_c ? mem[idx_c] : '0;
  end

  dm_lane_align u_align (
    .size        (cur_q.size),
    .addr_lo     (cur_q.addr[1:0]),
    .wdata       (cur_q.wdata),
    .ld_unsigned (cur_q.ld_unsigned),
    .rword       (rword_c),
    .be_c        (be_c),
    .wword_c     (wword_c),
    .ldata_c     (ldata_c)
  );

  // Memory array: only enabled lanes of a non-faulting store are written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (access_c && cur_q.we && !exc_c) begin
      for (int k = 0; k < int'(BE_W); k++) begin
        if (be_c[k]) mem[idx_c][8*k +: 8] <= wword_c[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
    end else begin
      busy     <= (state_d == ST_BUSY);
      done     <= (state_d == ST_DONE);
      exc_adel <= access_c && exc_c && !cur_q.we;
      exc_ades <= access_c && exc_c && cur_q.we;
      if (access_c) begin
        if (exc_c)          rdata <= '0;
        else if (!cur_q.we) rdata <= ldata_c;
      end
    end
  end

endmodule

// File: tb/tb_dm_multicycle.sv
// Self-checking bench for dm_multicycle: three instances with latency 1, 3, 4.
module tb_dm_multicycle;

  localparam int unsigned DEPTH = 3072;

  typedef struct {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        chk_rd;
  } exp_t;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic        we;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  busy, done, adel, ades;
  logic [31:0] rdata [3];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  dm_multicycle #(.DEPTH(DEPTH), .ADDR_BASE(32'h0), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we), .size(size),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .exc_adel(adel[0]), .exc_ades(ades[0]));

  dm_multicycle #(.DEPTH(DEPTH), .ADDR_BASE(32'h0), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we), .size(size),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .exc_adel(adel[1]), .exc_ades(ades[1]));

  dm_multicycle #(.DEPTH(DEPTH), .ADDR_BASE(32'h0), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we), .size(size),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy[2]), .done(done[2]), .rdata(rdata[2]),
    .exc_adel(adel[2]), .exc_ades(ades[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic add_vec(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ea, input logic es,
                         input logic crd);
    vec_t v;
    v.w = w; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
    v.e.rdata = er; v.e.adel = ea; v.e.ades = es; v.e.chk_rd = crd;
    vecs.push_back(v);
  endtask

  // One isolated access: checks done latency, busy length and scoreboard result.
  task automatic run_access(input int inst, input int lat, input vec_t v, input string tag);
    int   n;
    int   nbusy;
    bit   seen;
    exp_t ge;
    @(negedge clk);
    we = v.w; size = v.sz; ld_unsigned = v.uns; addr = v.a; wdata = v.wd;
    req[inst] = 1'b1;
    sb_q.push_back(v.e);
    @(posedge clk);
    n = 0; nbusy = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      req[inst] = 1'b0;
      if (done[inst]) seen = 1'b1;
      else if (busy[inst]) nbusy++;
    end
    chk($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
    ge = sb_q.pop_front();
    if (seen) begin
      chk($sformatf("%s_latency", tag), 32'(n), 32'(lat + 1));
      chk($sformatf("%s_busy_cycles", tag), 32'(nbusy), 32'(lat));
      if (ge.chk_rd) chk($sformatf("%s_rdata", tag), rdata[inst], ge.rdata);
      chk($sformatf("%s_adel", tag), 32'(adel[inst]), 32'(ge.adel));
      chk($sformatf("%s_ades", tag), 32'(ades[inst]), 32'(ge.ades));
    end
  endtask

  initial begin
    vec_t v;
    exp_t ge;
    int   dcnt;
    logic exp_busy, exp_done;

    req = '0; we = 1'b0; size = 2'b10; ld_unsigned = 1'b0; addr = '0; wdata = '0;
    reset = 1'b1;

    // Vector table for the latency-1 instance.
    add_vec(1, 2'b10, 0, 32'h0,    32'hDEAD_BEEF, 32'h0,         0, 0, 0); // sw
    add_vec(0, 2'b10, 0, 32'h0,    32'h0,         32'hDEAD_BEEF, 0, 0, 1); // lw
    add_vec(1, 2'b00, 0, 32'h1,    32'hAAAA_AA80, 32'h0,         0, 0, 0); // sb
    add_vec(0, 2'b10, 0, 32'h0,    32'h0,         32'hDEAD_80EF, 0, 0, 1); // lw
    add_vec(0, 2'b00, 0, 32'h1,    32'h0,         32'hFFFF_FF80, 0, 0, 1); // lb
    add_vec(0, 2'b00, 1, 32'h1,    32'h0,         32'h0000_0080, 0, 0, 1); // lbu
    add_vec(0, 2'b01, 0, 32'h2,    32'h0,         32'hFFFF_DEAD, 0, 0, 1); // lh
    add_vec(0, 2'b01, 1, 32'h2,    32'h0,         32'h0000_DEAD, 0, 0, 1); // lhu
    add_vec(1, 2'b01, 0, 32'h3,    32'h1111_1111, 32'h0,         0, 1, 1); // sh misaligned
    add_vec(0, 2'b10, 0, 32'h0,    32'h0,         32'hDEAD_80EF, 0, 0, 1); // unchanged
    add_vec(0, 2'b10, 0, 4*DEPTH,  32'h0,         32'h0,         1, 0, 1); // lw out of range
    add_vec(1, 2'b01, 0, 32'h6,    32'h5555_BEEF, 32'h0,         0, 0, 0); // sh upper half
    add_vec(0, 2'b01, 0, 32'h6,    32'h0,         32'hFFFF_BEEF, 0, 0, 1);
    add_vec(0, 2'b10, 0, 32'h4,    32'h0,         32'hBEEF_0000, 0, 0, 1);
    add_vec(0, 2'b00, 0, 32'h3,    32'h0,         32'hFFFF_FFDE, 0, 0, 1);
    add_vec(0, 2'b01, 1, 32'h0,    32'h0,         32'h0000_80EF, 0, 0, 1);
    add_vec(0, 2'b11, 0, 32'h2,    32'h0,         32'h0,         1, 0, 1); // size 11 as word
    add_vec(0, 2'b10, 0, 32'hFFFF_FFFC, 32'h0,    32'h0,         1, 0, 1);
    add_vec(0, 2'b00, 0, 4*DEPTH,  32'h0,         32'h0,         1, 0, 1);
    add_vec(1, 2'b10, 0, 4*DEPTH-4, 32'h0BAD_F00D, 32'h0,        0, 0, 0); // last word
    add_vec(0, 2'b10, 0, 4*DEPTH-4, 32'h0,        32'h0BAD_F00D, 0, 0, 1);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy",  32'(busy[0]),  32'd0);
    chk("reset_done",  32'(done[0]),  32'd0);
    chk("reset_rdata", rdata[0],      32'd0);
    chk("reset_adel",  32'(adel[0]),  32'd0);
    chk("reset_ades",  32'(ades[0]),  32'd0);

    // Reset one cycle after acceptance aborts the store (latency 3).
    we = 1'b1; size = 2'b10; ld_unsigned = 1'b0; addr = 32'h10; wdata = 32'h1234_5678;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    chk("abort_busy_before", 32'(busy[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy_cleared", 32'(busy[1]), 32'd0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done[1]) dcnt++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done[1]) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    v.w = 1'b0; v.sz = 2'b10; v.uns = 1'b0; v.a = 32'h10; v.wd = 32'h0;
    v.e.rdata = 32'h0; v.e.adel = 1'b0; v.e.ades = 1'b0; v.e.chk_rd = 1'b1;
    run_access(1, 3, v, "abort_lw");

    foreach (vecs[i]) run_access(0, 1, vecs[i], $sformatf("vec%0d", i));

    // Load accepted in the DONE cycle of a store to the same word.
    @(negedge clk);
    we = 1'b1; size = 2'b10; ld_unsigned = 1'b0; addr = 32'h40; wdata = 32'hCAFE_F00D;
    req[0] = 1'b1;
    ge.rdata = 32'hCAFE_F00D; ge.adel = 1'b0; ge.ades = 1'b0; ge.chk_rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_st_busy", 32'(busy[0]), 32'd1);
    we = 1'b0; wdata = 32'h0;
    @(negedge clk);
    chk("b2b_st_done", 32'(done[0]), 32'd1);
    sb_q.push_back(ge);
    @(negedge clk);
    req[0] = 1'b0;
    chk("b2b_ld_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("b2b_ld_done", 32'(done[0]), 32'd1);
    ge = sb_q.pop_front();
    chk("b2b_ld_rdata", rdata[0], ge.rdata);

    // Latency 4 with req held: period of 5, requests during BUSY ignored.
    @(negedge clk);
    we = 1'b0; size = 2'b10; ld_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    req[2] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_busy = (n <= 15) && (((n - 1) % 5) < 4);
      exp_done = (n <= 15) && (((n - 1) % 5) == 4);
      chk($sformatf("hold_c%0d_busy", n), 32'(busy[2]), 32'(exp_busy));
      chk($sformatf("hold_c%0d_done", n), 32'(done[2]), 32'(exp_done));
      if (n == 15) req[2] = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dm_multicycle.md
# dm_multicycle

Parametrised multi-cycle data memory for the pipelined MIPS core. It generalises the word-only, zero-latency data memory in three ways: byte/halfword/word access with load sign- or zero-extension, a programmable access latency with a req/busy/done handshake, and address-exception reporting. It sits behind the MEM stage, and the stall controller freezes the pipeline while `busy` is high.

## Interface
- `DEPTH`, default 3072: memory size in 32-bit words; legal byte addresses are `ADDR_BASE` to `ADDR_BASE + 4*DEPTH - 1`.
- `ADDR_BASE`, default 32'h0000_0000: byte address of word 0.
- `LATENCY`, default 1: access latency in cycles, legal range 1..15.

- `clk`  in  1  — single clock. All state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high. Clears all state and all memory.
- `req`  in  1  — access request. Sampled only when `busy`=0.
- `we`  in  1  — 1 = store, 0 = load.
- `size`  in  2  — access size: 2'b00 byte, 2'b01 half, 2'b10 word. 2'b11 is treated as word.
- `ld_unsigned`  in  1  — 1 = zero-extend the load result (lbu/lhu); ignored for word accesses.
- `addr`  in  32  — byte address.
- `wdata`  in  32  — store data, taken from the low bits (sb: [7:0], sh: [15:0]).
- `busy`  out  1  — access in flight; a new request is not accepted.
- `done`  out  1  — one-cycle pulse when the access completes.
- `rdata`  out  32  — extended load result; holds its value until the next `done`.
- `exc_adel`  out  1  — load address error, valid while `done`=1.
- `exc_ades`  out  1  — store address error, valid while `done`=1.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **Acceptance:**
  - A request is accepted on an edge where `req`=1 and the state is IDLE or DONE.
  - On acceptance, capture `we`, `size`, `ld_unsigned`, `addr` and `wdata`, load the counter with `LATENCY`, and go to BUSY.
- **BUSY:**
  - The counter decrements on each edge.
  - On the edge where the counter equals 1, perform the access and go to DONE.
- **DONE:** lasts one cycle. It returns to IDLE, or goes to BUSY if a new request is accepted on that edge.
- **Outputs:** `busy` = (state == BUSY). `done` = (state == DONE).
- **Exception check** (evaluated on the captured request):
  - Misaligned: half with addr[0]≠0, or word with addr[1:0]≠0.
  - Out of range: addr < `ADDR_BASE` or addr ≥ `ADDR_BASE` + 4·`DEPTH`.
  - On an exception, no memory write occurs, `rdata` is set to 0, and `exc_ades` (store) or `exc_adel` (load) is raised during DONE.
- **Memory layout:** word index = (addr − `ADDR_BASE`) >> 2. Little-endian: byte lane k = addr[1:0], bits [8k+7:8k].
- **Stores:** only the addressed lanes are written (sb: 1 lane, sh: lanes {addr[1],0}/{addr[1],1}, sw: all 4).
- **Loads:** extract the addressed lanes, then sign-extend (`ld_unsigned`=0) or zero-extend (`ld_unsigned`=1) to 32 bits.
- **Ignored requests:** a `req` asserted while `busy`=1 is ignored. The requester holds `req` until it is accepted.

## Timing
- **Reset values:** state IDLE, counter 0, `busy` 0, `done` 0, `rdata` 0, `exc_adel` 0, `exc_ades` 0, all memory words 0.
- **Latency:** with the request accepted at edge E:
  - `busy`=1 in the cycles after edges E … E+LATENCY−1.
  - The write commits and `rdata` updates at edge E+LATENCY.
  - `done`=1 in the cycle after edge E+LATENCY.
- **Throughput:** back-to-back requests accepted in DONE give one access every `LATENCY`+1 cycles.
- **Reset mid-access:** aborts the access immediately. No write occurs, and no `done` is produced.
- **Load after store:** a load accepted in the DONE cycle of a store to the same word returns the newly stored data.

## Structure
- **Shared header constants:** size encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`) and FSM state encodings.
- **Sub-module `dm_lane_align`** (combinational):
  - Store side: computes the 4-bit byte-enable and lane-shifted write word from size, addr[1:0] and wdata.
  - Load side: extracts the addressed lanes from the read word and extends the result.
- **Top module:** FSM, 4-bit counter, capture registers, memory array, exception logic.

## Test plan
- **Reset-mid-access:** `LATENCY`=3. Issue sw 32'h1234_5678 to addr 0x10, then assert `reset` one cycle after acceptance. Required: `done` never pulses, and a subsequent lw of 0x10 returns 0.
- **Word store/load:** `LATENCY`=1. sw 32'hDEAD_BEEF to 0x0, then lw 0x0. Required: `done` in the 2nd cycle after each acceptance, `rdata`=32'hDEAD_BEEF.
- **Byte/half lanes and extension:** after the word above:
  - sb 8'h80 to 0x1 → word becomes 32'hDEAD_80EF.
  - lb 0x1 → 32'hFFFF_FF80; lbu 0x1 → 32'h0000_0080.
  - lh 0x2 → 32'hFFFF_DEAD; lhu 0x2 → 32'h0000_DEAD.
- **Latency/handshake:** `LATENCY`=4 with `req` held high continuously. Required: `busy` high for 4 cycles, `done` for 1 cycle, next acceptance in the DONE cycle, period 5 cycles, and requests during BUSY ignored.
- **Address exceptions:**
  - sh to 0x3 → `exc_ades`=1 with `done`, memory unchanged.
  - lw to 4·`DEPTH` → `exc_adel`=1, `rdata`=0.
